// File: rtl/blob_centroid_tracker.sv
// Per-channel blob centroid tracker over a raster mask stream.
// Optional bounding box enabled by defining BLOB_CENTROID_BBOX_EN.
module blob_centroid_tracker #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int NUM_CH      = 2,
  parameter int MIN_ROW_PIX = 4,
  parameter int MIN_ROWS    = 4,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H),
  localparam int PW = $clog2(IMG_W * IMG_H + 1),
  localparam int HW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDVAL,
  input  logic [NUM_CH-1:0] iMask,
  input  logic              iREADY,
  output logic              oVALID,
  output logic [HW-1:0]     oChan,
  output logic [CW-1:0]     oCol,
  output logic [RW-1:0]     oRow,
  output logic [PW-1:0]     oCount,
  output logic              oPresent,
  output logic              oDROP,
  output logic [CW-1:0]     oXMin,
  output logic [CW-1:0]     oXMax,
  output logic [RW-1:0]     oYMin,
  output logic [RW-1:0]     oYMax
);

  localparam int XW = PW + CW;
  localparam int YW = PW + RW;
  localparam int NW = CW + 1;
  localparam int SW = 2 * CW;
  localparam int AW = RW + 1;
  localparam int DW = (CW > RW) ? CW : RW;
  localparam int KW = $clog2(DW) + 1;

  typedef enum logic [1:0] {
    IDLE, DIV_X, DIV_Y, OUT
  } state_t;

  state_t state;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          sol, eol, eof, sof, snap;

  assign sol  = (col == '0);
  assign eol  = iDVAL && (col == CW'(IMG_W - 1));
  assign eof  = eol && (row == RW'(IMG_H - 1));
  assign sof  = iDVAL && sol && (row == '0);
  assign snap = eof && (state == IDLE);

  logic [NW-1:0] row_cnt [NUM_CH];
  logic [NW-1:0] rc_n    [NUM_CH];
  logic [SW-1:0] row_xs  [NUM_CH];
  logic [SW-1:0] rx_n    [NUM_CH];
  logic [XW-1:0] fx      [NUM_CH];
  logic [XW-1:0] fx_n    [NUM_CH];
  logic [YW-1:0] fy      [NUM_CH];
  logic [YW-1:0] fy_n    [NUM_CH];
  logic [PW-1:0] fc      [NUM_CH];
  logic [PW-1:0] fc_n    [NUM_CH];
  logic [AW-1:0] ar      [NUM_CH];
  logic [AW-1:0] ar_n    [NUM_CH];
  logic          qual    [NUM_CH];

  logic [XW-1:0] bx [NUM_CH];
  logic [YW-1:0] by [NUM_CH];
  logic [PW-1:0] bc [NUM_CH];
  logic          bp [NUM_CH];

  logic [HW-1:0] ch, nxt;
  logic [KW-1:0] k;
  logic [PW-1:0] rem, rem_n;
  logic [DW-1:0] q, q_n;
  logic [CW-1:0] qx;
  logic [PW:0]   trial, dvs;
  logic          dbit, ge, ld_abs, ld_pres;

  // Raster position: advances only on valid pixels
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      col <= '0;
      row <= '0;
    end else if (iDVAL) begin
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Next row/frame sums including the current pixel
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      rc_n[c] = (sol ? '0 : row_cnt[c]) + NW'(iMask[c]);
      rx_n[c] = (sol ? '0 : row_xs[c]) + (iMask[c] ? SW'(col) : '0);
      qual[c] = eol && (rc_n[c] >= NW'(MIN_ROW_PIX));
      fx_n[c] = (sof ? '0 : fx[c]) + (qual[c] ? XW'(rx_n[c]) : '0);
      fy_n[c] = (sof ? '0 : fy[c])
              + (qual[c] ? YW'(row) * YW'(rc_n[c]) : '0);
      fc_n[c] = (sof ? '0 : fc[c]) + (qual[c] ? PW'(rc_n[c]) : '0);
      ar_n[c] = (sof ? '0 : ar[c]) + AW'(qual[c]);
    end
  end

  // Row and frame accumulators
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        row_cnt[c] <= '0;
        row_xs[c]  <= '0;
        fx[c]      <= '0;
        fy[c]      <= '0;
        fc[c]      <= '0;
        ar[c]      <= '0;
      end
    end else if (iDVAL) begin
      for (int c = 0; c < NUM_CH; c++) begin
        row_cnt[c] <= rc_n[c];
        row_xs[c]  <= rx_n[c];
        fx[c]      <= fx_n[c];
        fy[c]      <= fy_n[c];
        fc[c]      <= fc_n[c];
        ar[c]      <= ar_n[c];
      end
    end
  end

  // Result bank captured at frame end when the FSM is free
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bx[c] <= '0;
        by[c] <= '0;
        bc[c] <= '0;
        bp[c] <= 1'b0;
      end
    end else if (snap) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bx[c] <= fx_n[c];
        by[c] <= fy_n[c];
        bc[c] <= fc_n[c];
        bp[c] <= (ar_n[c] >= AW'(MIN_ROWS));
      end
    end
  end

  // Restoring divider step, one quotient bit per cycle
  always_comb begin
    nxt   = ch + HW'(1);
    dbit  = (state == DIV_Y) ? |(by[ch] & (YW'(1) << k))
                             : |(bx[ch] & (XW'(1) << k));
    trial = {rem, dbit};
    dvs   = {1'b0, bc[ch]};
    ge    = (trial >= dvs);
    rem_n = ge ? PW'(trial - dvs) : PW'(trial);
    q_n   = (q << 1) | DW'(ge);
    ld_abs  = (state == DIV_X) && !bp[ch];
    ld_pres = (state == DIV_Y) && (k == '0);
  end

  // Channel sequencer, divider and registered result outputs
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      ch       <= '0;
      k        <= '0;
      rem      <= '0;
      q        <= '0;
      qx       <= '0;
      oVALID   <= 1'b0;
      oChan    <= '0;
      oCol     <= '0;
      oRow     <= '0;
      oCount   <= '0;
      oPresent <= 1'b0;
      oDROP    <= 1'b0;
    end else begin
      oDROP <= eof && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (snap) begin
            state <= DIV_X;
            ch    <= '0;
            k     <= KW'(CW - 1);
            q     <= '0;
            rem   <= PW'(fx_n[0] >> CW);
          end
        end
        DIV_X: begin
          if (!bp[ch]) begin
            state    <= OUT;
            oVALID   <= 1'b1;
            oChan    <= ch;
            oCol     <= '0;
            oRow     <= '0;
            oCount   <= '0;
            oPresent <= 1'b0;
          end else if (k == '0) begin
            qx    <= CW'(q_n);
            state <= DIV_Y;
            k     <= KW'(RW - 1);
            q     <= '0;
            rem   <= PW'(by[ch] >> RW);
          end else begin
            rem <= rem_n;
            q   <= q_n;
            k   <= k - KW'(1);
          end
        end
        DIV_Y: begin
          rem <= rem_n;
          q   <= q_n;
          if (k == '0) begin
            state    <= OUT;
            oVALID   <= 1'b1;
            oChan    <= ch;
            oCol     <= qx;
            oRow     <= RW'(q_n);
            oCount   <= bc[ch];
            oPresent <= 1'b1;
          end else begin
            k <= k - KW'(1);
          end
        end
        OUT: begin
          if (iREADY) begin
            oVALID <= 1'b0;
            if (ch == HW'(NUM_CH - 1)) begin
              state <= IDLE;
            end else begin
              ch    <= nxt;
              state <= DIV_X;
              k     <= KW'(CW - 1);
              q     <= '0;
              rem   <= PW'(bx[nxt] >> CW);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BLOB_CENTROID_BBOX_EN
  logic [CW-1:0] rxmin  [NUM_CH];
  logic [CW-1:0] rxmax  [NUM_CH];
  logic [CW-1:0] rxmin_n[NUM_CH];
  logic [CW-1:0] rxmax_n[NUM_CH];
  logic [CW-1:0] fxmin  [NUM_CH];
  logic [CW-1:0] fxmax  [NUM_CH];
  logic [RW-1:0] fymin  [NUM_CH];
  logic [RW-1:0] fymax  [NUM_CH];
  logic [CW-1:0] fxmin_n[NUM_CH];
  logic [CW-1:0] fxmax_n[NUM_CH];
  logic [RW-1:0] fymin_n[NUM_CH];
  logic [RW-1:0] fymax_n[NUM_CH];
  logic [CW-1:0] fxmin_b[NUM_CH];
  logic [CW-1:0] fxmax_b[NUM_CH];
  logic [RW-1:0] fymin_b[NUM_CH];
  logic [RW-1:0] fymax_b[NUM_CH];
  logic [CW-1:0] rxmin_b[NUM_CH];
  logic [CW-1:0] rxmax_b[NUM_CH];
  logic [CW-1:0] bxmin  [NUM_CH];
  logic [CW-1:0] bxmax  [NUM_CH];
  logic [RW-1:0] bymin  [NUM_CH];
  logic [RW-1:0] bymax  [NUM_CH];

  // Row extents merged into the frame box on qualifying rows only
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      rxmin_b[c] = sol ? '1 : rxmin[c];
      rxmax_b[c] = sol ? '0 : rxmax[c];
      rxmin_n[c] = (iMask[c] && col < rxmin_b[c]) ? col : rxmin_b[c];
      rxmax_n[c] = iMask[c] ? col : rxmax_b[c];
      fxmin_b[c] = sof ? '1 : fxmin[c];
      fxmax_b[c] = sof ? '0 : fxmax[c];
      fymin_b[c] = sof ? '1 : fymin[c];
      fymax_b[c] = sof ? '0 : fymax[c];
      fxmin_n[c] = (qual[c] && rxmin_n[c] < fxmin_b[c])
                 ? rxmin_n[c] : fxmin_b[c];
      fxmax_n[c] = (qual[c] && rxmax_n[c] > fxmax_b[c])
                 ? rxmax_n[c] : fxmax_b[c];
      fymin_n[c] = (qual[c] && row < fymin_b[c]) ? row : fymin_b[c];
      fymax_n[c] = (qual[c] && row > fymax_b[c]) ? row : fymax_b[c];
    end
  end

  // Bounding box tracking, banking and output registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rxmin[c] <= '1;
        rxmax[c] <= '0;
        fxmin[c] <= '1;
        fxmax[c] <= '0;
        fymin[c] <= '1;
        fymax[c] <= '0;
        bxmin[c] <= '0;
        bxmax[c] <= '0;
        bymin[c] <= '0;
        bymax[c] <= '0;
      end
      oXMin <= '0;
      oXMax <= '0;
      oYMin <= '0;
      oYMax <= '0;
    end else begin
      if (iDVAL) begin
        for (int c = 0; c < NUM_CH; c++) begin
          rxmin[c] <= rxmin_n[c];
          rxmax[c] <= rxmax_n[c];
          fxmin[c] <= fxmin_n[c];
          fxmax[c] <= fxmax_n[c];
          fymin[c] <= fymin_n[c];
          fymax[c] <= fymax_n[c];
        end
      end
      if (snap) begin
        for (int c = 0; c < NUM_CH; c++) begin
          bxmin[c] <= fxmin_n[c];
          bxmax[c] <= fxmax_n[c];
          bymin[c] <= fymin_n[c];
          bymax[c] <= fymax_n[c];
        end
      end
      if (ld_abs) begin
        oXMin <= '0;
        oXMax <= '0;
        oYMin <= '0;
        oYMax <= '0;
      end else if (ld_pres) begin
        oXMin <= bxmin[ch];
        oXMax <= bxmax[ch];
        oYMin <= bymin[ch];
        oYMax <= bymax[ch];
      end
    end
  end
`else
  assign oXMin = '0;
  assign oXMax = '0;
  assign oYMin = '0;
  assign oYMax = '0;
`endif

endmodule

// File: tb/tb_blob_centroid_tracker.sv
// Scoreboard bench for blob_centroid_tracker on a reduced 120x32 image.
// Bbox expectations follow BLOB_CENTROID_BBOX_EN.
module tb_blob_centroid_tracker;

  localparam int W  = 120;
  localparam int H  = 32;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam int PW = $clog2(W * H + 1);
  localparam int LAT_P = CW + RW + 1;
`ifdef BLOB_CENTROID_BBOX_EN
  localparam bit BB = 1'b1;
`else
  localparam bit BB = 1'b0;
`endif

  logic          iCLK = 1'b0;
  logic          iRST, iDVAL, iREADY;
  logic [1:0]    iMask;
  logic          oVALID, oPresent, oDROP;
  logic [0:0]    oChan;
  logic [CW-1:0] oCol, oXMin, oXMax;
  logic [RW-1:0] oRow, oYMin, oYMax;
  logic [PW-1:0] oCount;

  blob_centroid_tracker #(.IMG_W(W), .IMG_H(H)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iMask(iMask),
    .iREADY(iREADY), .oVALID(oVALID), .oChan(oChan), .oCol(oCol),
    .oRow(oRow), .oCount(oCount), .oPresent(oPresent), .oDROP(oDROP),
    .oXMin(oXMin), .oXMax(oXMax), .oYMin(oYMin), .oYMax(oYMax)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int chan, col, row, cnt, pres;
    int xmin, xmax, ymin, ymax;
  } exp_t;

  exp_t sb[$];
  int applied = 0;
  int miscompares = 0;
  int drop_cycles = 0;
  int rx0[2], rx1[2], ry0[2], ry1[2];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic push(input int chn, input int c, input int r,
                      input int n, input int p, input int x0,
                      input int x1, input int y0, input int y1);
    exp_t e;
    e.chan = chn; e.col = c; e.row = r; e.cnt = n; e.pres = p;
    e.xmin = BB ? x0 : 0;
    e.xmax = BB ? x1 : 0;
    e.ymin = BB ? y0 : 0;
    e.ymax = BB ? y1 : 0;
    sb.push_back(e);
  endtask

  task automatic set_rect(input int chn, input int x0, input int x1,
                          input int y0, input int y1);
    rx0[chn] = x0; rx1[chn] = x1; ry0[chn] = y0; ry1[chn] = y1;
  endtask

  task automatic clr_rects();
    set_rect(0, 1, 0, 1, 0);
    set_rect(1, 1, 0, 1, 0);
  endtask

  task automatic drive_rows(input int nrows);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < W; c++) begin
        iDVAL = 1'b1;
        for (int h = 0; h < 2; h++)
          iMask[h] = (c >= rx0[h] && c <= rx1[h] &&
                      r >= ry0[h] && r <= ry1[h]);
        step();
      end
    end
    iDVAL = 1'b0;
    iMask = '0;
  endtask

  // Cycles from the frame's last pixel being presented to oVALID
  task automatic wait_valid(input string nm, input int exp_lat);
    int lat = 1;
    while (!oVALID && lat < 200) begin
      step();
      lat++;
    end
    chk(nm, lat, exp_lat);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  logic [63:0] cur, prev;
  bit held = 1'b0;
  exp_t e;

  // Monitor: stall stability, drop counting, scoreboard pops
  always @(negedge iCLK) begin
    if (iRST) begin
      held = 1'b0;
    end else begin
      cur = {13'd0, oVALID, oChan, oCol, oRow, oCount, oPresent,
             oXMin, oXMax, oYMin, oYMax};
      if (held) chk("hold_stable", cur, prev);
      if (oDROP) drop_cycles++;
      if (oVALID && iREADY) begin
        if (sb.size() == 0) begin
          applied++;
          miscompares++;
          $display("FAIL unexpected_result: chan %0d with empty queue",
                   oChan);
        end else begin
          e = sb.pop_front();
          chk("chan", oChan, e.chan);
          chk("col", oCol, e.col);
          chk("row", oRow, e.row);
          chk("count", oCount, e.cnt);
          chk("present", oPresent, e.pres);
          chk("xmin", oXMin, e.xmin);
          chk("xmax", oXMax, e.xmax);
          chk("ymin", oYMin, e.ymin);
          chk("ymax", oYMax, e.ymax);
        end
      end
      held = oVALID && !iREADY;
      prev = cur;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    iRST = 1'b1; iDVAL = 1'b0; iMask = '0; iREADY = 1'b1;
    clr_rects();
    repeat (3) step();
    iRST = 1'b0;
    chk("rst_valid", oVALID, 0);
    chk("rst_drop", oDROP, 0);
    chk("rst_count", oCount, 0);
    chk("rst_col_row", {oCol, oRow}, 0);
    chk("rst_present", oPresent, 0);

    // 8x8 square on ch0: col 103.5 -> 103, row 23.5 -> 23
    set_rect(0, 100, 107, 20, 27);
    push(0, 103, 23, 64, 1, 100, 107, 20, 27);
    push(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_rows(H);
    wait_valid("lat_present", LAT_P);
    drain();

    // 3 hits per row never qualify; ch1 has exactly 4 rows of 4 hits
    clr_rects();
    set_rect(0, 0, 2, 0, H - 1);
    set_rect(1, 60, 63, 10, 13);
    push(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(1, 61, 11, 16, 1, 60, 63, 10, 13);
    drive_rows(H);
    wait_valid("lat_absent", 2);
    drain();

    // Backpressure for 50 cycles during OUT
    clr_rects();
    set_rect(0, 100, 107, 20, 27);
    push(0, 103, 23, 64, 1, 100, 107, 20, 27);
    push(1, 0, 0, 0, 0, 0, 0, 0, 0);
    iREADY = 1'b0;
    drive_rows(H);
    wait_valid("lat_stall", LAT_P);
    repeat (50) step();
    chk("stall_valid", oVALID, 1);
    iREADY = 1'b1;
    step();
    chk("advance_on_ready", oVALID, 0);
    drain();

    // Stall across a whole second frame: that frame is dropped
    clr_rects();
    set_rect(1, 50, 59, 2, 9);
    push(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(1, 54, 5, 80, 1, 50, 59, 2, 9);
    iREADY = 1'b0;
    drive_rows(H);
    chk("no_drop_first", drop_cycles, 0);
    clr_rects();
    set_rect(0, 100, 107, 20, 27);
    drive_rows(H);
    chk("drop_pulse", oDROP, 1);
    step();
    chk("drop_one_cycle", oDROP, 0);
    iREADY = 1'b1;
    drain();

    // Reset mid-frame after hits, then a clean frame
    clr_rects();
    set_rect(0, 100, 107, 5, 12);
    set_rect(1, 0, W - 1, 0, 15);
    drive_rows(16);
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    chk("midrst_valid", oVALID, 0);
    chk("midrst_count", oCount, 0);
    clr_rects();
    set_rect(0, 100, 107, 20, 27);
    push(0, 103, 23, 64, 1, 100, 107, 20, 27);
    push(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_rows(H);
    wait_valid("lat_after_rst", LAT_P);
    drain();

    // ch1 box: cols 10-29 rows 5-14, col 19.5 -> 19, row 9.5 -> 9
    clr_rects();
    set_rect(1, 10, 29, 5, 14);
    push(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(1, 19, 9, 200, 1, 10, 29, 5, 14);
    drive_rows(H);
    drain();

    repeat (5) step();
    chk("drop_total", drop_cycles, 1);
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
